// File: rtl/soc_bus_arbiter_if.sv
// Bundle of both masters' request/response signals plus the downstream address/data bus.
// m0_lock/m1_lock exist only when ARB_LOCK_EN is defined.
interface soc_bus_arbiter_if #(
   parameter int unsigned AW = 32,
   parameter int unsigned DW = 32
);
   logic          m0_req;
   logic          m0_we;
   logic [AW-1:0] m0_addr;
   logic [DW-1:0] m0_wdata;
   logic [DW-1:0] m0_rdata;
   logic          m0_ack;
   logic          m0_err;

   logic          m1_req;
   logic          m1_we;
   logic [AW-1:0] m1_addr;
   logic [DW-1:0] m1_wdata;
   logic [DW-1:0] m1_rdata;
   logic          m1_ack;
   logic          m1_err;

`ifdef ARB_LOCK_EN
   logic          m0_lock;
   logic          m1_lock;
`endif

   logic          bus_we;
   logic [AW-1:0] bus_addr;
   logic [DW-1:0] bus_wdata;
   logic [DW-1:0] bus_rdata;
   logic          bus_rdy;

   // slave: the arbiter itself; master: requesters together with the downstream decoder
   modport slave (
`ifdef ARB_LOCK_EN
      input  m0_lock, m1_lock,
`endif
      input  m0_req, m0_we, m0_addr, m0_wdata,
      output m0_rdata, m0_ack, m0_err,
      input  m1_req, m1_we, m1_addr, m1_wdata,
      output m1_rdata, m1_ack, m1_err,
      output bus_we, bus_addr, bus_wdata,
      input  bus_rdata, bus_rdy
   );

   modport master (
`ifdef ARB_LOCK_EN
      output m0_lock, m1_lock,
`endif
      output m0_req, m0_we, m0_addr, m0_wdata,
      input  m0_rdata, m0_ack, m0_err,
      output m1_req, m1_we, m1_addr, m1_wdata,
      input  m1_rdata, m1_ack, m1_err,
      input  bus_we, bus_addr, bus_wdata,
      output bus_rdata, bus_rdy
   );
endinterface

// File: rtl/soc_bus_arbiter.sv
// Two-master round-robin arbiter for the SoC memory-mapped bus with wait-state timeout.
// Define ARB_LOCK_EN to add m0_lock/m1_lock, which let the granted master keep priority.
module soc_bus_arbiter #(
   parameter int unsigned AW     = 32,
   parameter int unsigned DW     = 32,
   parameter int unsigned TO_CYC = 15
) (
   input logic              clk,
   input logic              rst,
   soc_bus_arbiter_if.slave bus
);
   localparam int unsigned CW = (TO_CYC > 1) ? $clog2(TO_CYC) : 1;

   typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

   state_e        r_state;
   logic          r_gnt;
   logic          r_prio;
   logic [CW-1:0] r_to_cnt;
   logic [DW-1:0] r_rdata0;
   logic [DW-1:0] r_rdata1;
   logic          r_ack0;
   logic          r_ack1;
   logic          r_err0;
   logic          r_err1;

   logic          w_we;
   logic [AW-1:0] w_addr;
   logic [DW-1:0] w_wdata;
   logic          w_timeout;
   logic          w_lock;

   // Downstream bus is only live during ACCESS; zero everywhere else
   always_comb begin
      w_we    = 1'b0;
      w_addr  = '0;
      w_wdata = '0;
      if (r_state == StAccess) begin
         if (r_gnt) begin
            w_we    = bus.m1_we;
            w_addr  = bus.m1_addr;
            w_wdata = bus.m1_wdata;
         end else begin
            w_we    = bus.m0_we;
            w_addr  = bus.m0_addr;
            w_wdata = bus.m0_wdata;
         end
      end
   end

   assign bus.bus_we    = w_we;
   assign bus.bus_addr  = w_addr;
   assign bus.bus_wdata = w_wdata;

   // Counter holds the number of wait cycles already spent before this one
   assign w_timeout = (TO_CYC != 0) && (r_to_cnt == CW'(TO_CYC - 1));

`ifdef ARB_LOCK_EN
   assign w_lock = r_gnt ? bus.m1_lock : bus.m0_lock;
`else
   assign w_lock = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= StIdle;
         r_gnt    <= 1'b0;
         r_prio   <= 1'b0;
         r_to_cnt <= '0;
         r_rdata0 <= '0;
         r_rdata1 <= '0;
         r_ack0   <= 1'b0;
         r_ack1   <= 1'b0;
         r_err0   <= 1'b0;
         r_err1   <= 1'b0;
      end else begin
         r_ack0 <= 1'b0;
         r_ack1 <= 1'b0;
         unique case (r_state)
            StIdle: begin
               if (bus.m0_req || bus.m1_req) begin
                  r_gnt    <= (bus.m0_req && bus.m1_req) ? r_prio : bus.m1_req;
                  r_to_cnt <= '0;
                  r_state  <= StAccess;
               end
            end
            StAccess: begin
               if (bus.bus_rdy) begin
                  if (r_gnt) begin
                     r_rdata1 <= bus.bus_rdata;
                     r_err1   <= 1'b0;
                     r_ack1   <= 1'b1;
                  end else begin
                     r_rdata0 <= bus.bus_rdata;
                     r_err0   <= 1'b0;
                     r_ack0   <= 1'b1;
                  end
                  r_state <= StResp;
               end else begin
                  r_to_cnt <= r_to_cnt + CW'(1);
                  if (w_timeout) begin
                     if (r_gnt) begin
                        r_rdata1 <= '0;
                        r_err1   <= 1'b1;
                        r_ack1   <= 1'b1;
                     end else begin
                        r_rdata0 <= '0;
                        r_err0   <= 1'b1;
                        r_ack0   <= 1'b1;
                     end
                     r_state <= StResp;
                  end
               end
            end
            StResp: begin
               // A locked master keeps priority; otherwise the one just served drops to lowest
               r_prio  <= w_lock ? r_gnt : ~r_gnt;
               r_state <= StIdle;
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   assign bus.m0_rdata = r_rdata0;
   assign bus.m0_ack   = r_ack0;
   assign bus.m0_err   = r_err0;
   assign bus.m1_rdata = r_rdata1;
   assign bus.m1_ack   = r_ack1;
   assign bus.m1_err   = r_err1;
endmodule
